// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding and
// an index-width helper used for requester indices and the latency counter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_e;

  // Width able to index 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request found when
// scanning from ptr upward (mod NREQ), plus a flag that any request is set.
module bus_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   winner_o,
  output logic            any_req_o
);

  logic [IW-1:0] idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    winner_o  = '0;
    any_req_o = |req_i;
    idx       = '0;
    // Scan from the farthest offset down so the closest match to ptr wins last.
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr_i) + i) % NREQ);
      if (req_i[idx]) begin
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares one memory/peripheral port among NREQ
// requesters, holding the port MEM_LAT cycles per access and acking once.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 64,
  parameter int AW      = 64,
  parameter int MEM_LAT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  ack,
  output logic [DW-1:0]    rdata,
  output logic             mem_en,
  output logic             mem_write,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = idx_width(MEM_LAT);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_write_q, mem_write_d;

  logic [IW-1:0]   pick_win;
  logic            pick_any;

  bus_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .winner_o  (pick_win),
    .any_req_o (pick_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Next-state: request capture at grant, latency countdown, pointer rotation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d   = pick_win;
          wr_d    = req_write[pick_win];
          addr_d  = req_addr[int'(pick_win)*AW +: AW];
          wdata_d = req_wdata[int'(pick_win)*DW +: DW];
          cnt_d   = CW'(MEM_LAT - 1);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they belong to.
  always_comb begin
    gnt_d       = '0;
    ack_d       = '0;
    mem_en_d    = 1'b0;
    mem_write_d = 1'b0;
    rdata_d     = rdata_q;
    if (state_d != ST_IDLE) begin
      gnt_d = NREQ'(1) << win_d;
    end
    if (state_d == ST_ACK) begin
      ack_d = NREQ'(1) << win_d;
    end
    if (state_d == ST_ACCESS) begin
      mem_en_d    = 1'b1;
      mem_write_d = wr_d;
    end
    if (state_q == ST_ACCESS && cnt_q == '0 && !wr_q) begin
      rdata_d = mem_rdata;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, single read/write, pointer wrap,
// reset during an access, full contention and request drop mid-access.
module tb_bus_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 64;
  localparam int AW      = 64;
  localparam int MEM_LAT = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               mem_en;
  logic               mem_write;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  bus_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .AW      (AW),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_slot(input int i, input logic wr, input logic [63:0] a, input logic [63:0] d);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // One complete transaction from the IDLE cycle where the request is visible.
  task automatic serve(input string tag, input logic [3:0] g, input logic wr,
                       input logic [63:0] ea, input logic [63:0] ew, input logic [63:0] er);
    tick();
    check({tag, "/gnt"},       64'(gnt),       64'(g));
    check({tag, "/mem_en1"},   64'(mem_en),    64'd1);
    check({tag, "/mem_wr1"},   64'(mem_write), 64'(wr));
    check({tag, "/mem_addr"},  mem_addr,       ea);
    check({tag, "/mem_wdata"}, mem_wdata,      ew);
    check({tag, "/ack_early"}, 64'(ack),       64'd0);
    tick();
    check({tag, "/mem_en2"},   64'(mem_en),    64'd1);
    check({tag, "/mem_wr2"},   64'(mem_write), 64'(wr));
    check({tag, "/ack_early2"}, 64'(ack),      64'd0);
    tick();
    check({tag, "/ack"},       64'(ack),       64'(g));
    check({tag, "/gnt_ack"},   64'(gnt),       64'(g));
    check({tag, "/mem_en_off"}, 64'(mem_en),   64'd0);
    check({tag, "/mem_wr_off"}, 64'(mem_write), 64'd0);
    check({tag, "/rdata"},     rdata,          er);
    req = req & ~g;
    tick();
    check({tag, "/ack_off"},   64'(ack),       64'd0);
    check({tag, "/gnt_off"},   64'(gnt),       64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_rdata = '0;
    tick();
    tick();
    check("rst/gnt",       64'(gnt),       64'd0);
    check("rst/ack",       64'(ack),       64'd0);
    check("rst/rdata",     rdata,          64'd0);
    check("rst/mem_en",    64'(mem_en),    64'd0);
    check("rst/mem_write", 64'(mem_write), 64'd0);
    check("rst/mem_addr",  mem_addr,       64'd0);
    check("rst/mem_wdata", mem_wdata,      64'd0);

    // Single read from requester 0.
    reset = 1'b0;
    set_slot(0, 1'b0, 64'h40, 64'h0);
    req       = 4'b0001;
    mem_rdata = 64'hDEAD_BEEF;
    serve("read", 4'b0001, 1'b0, 64'h40, 64'h0, 64'hDEAD_BEEF);

    // Single write from requester 2; rdata must keep the previous read value.
    set_slot(2, 1'b1, 64'h80, 64'h1234);
    req       = 4'b0100;
    mem_rdata = 64'h0BAD_0BAD;
    serve("write", 4'b0100, 1'b1, 64'h80, 64'h1234, 64'hDEAD_BEEF);

    // Pointer at 3 with requesters 3 and 0: 3 wins, then 0, then late-raised 2.
    set_slot(3, 1'b0, 64'h300, 64'h33);
    set_slot(0, 1'b0, 64'h100, 64'h11);
    req       = 4'b1001;
    mem_rdata = 64'hA3;
    serve("wrap3", 4'b1000, 1'b0, 64'h300, 64'h33, 64'hA3);
    set_slot(2, 1'b0, 64'h200, 64'h22);
    req[2]    = 1'b1;
    mem_rdata = 64'hA0;
    serve("wrap0", 4'b0001, 1'b0, 64'h100, 64'h11, 64'hA0);
    mem_rdata = 64'hA2;
    serve("wrap2", 4'b0100, 1'b0, 64'h200, 64'h22, 64'hA2);

    // Reset for three cycles in the middle of an access by requester 1.
    set_slot(1, 1'b0, 64'h110, 64'h1);
    req       = 4'b0010;
    mem_rdata = 64'hCC;
    tick();
    check("rstmid/gnt",    64'(gnt),    64'b0010);
    tick();
    check("rstmid/mem_en", 64'(mem_en), 64'd1);
    reset = 1'b1;
    tick();
    check("rstmid/gnt0",       64'(gnt),       64'd0);
    check("rstmid/ack0",       64'(ack),       64'd0);
    check("rstmid/mem_en0",    64'(mem_en),    64'd0);
    check("rstmid/mem_write0", 64'(mem_write), 64'd0);
    check("rstmid/mem_addr0",  mem_addr,       64'd0);
    check("rstmid/mem_wdata0", mem_wdata,      64'd0);
    check("rstmid/rdata0",     rdata,          64'd0);
    tick();
    check("rstmid/ack1", 64'(ack), 64'd0);
    tick();
    check("rstmid/ack2", 64'(ack), 64'd0);
    reset = 1'b0;

    // Full contention: grants rotate 0,1,2,3,0 with requests reissued after each ack.
    for (int i = 0; i < NREQ; i++) begin
      set_slot(i, 1'b0, 64'h1000 + 64'(i * 16), 64'(i));
    end
    req       = 4'b1111;
    mem_rdata = 64'h55;
    for (int k = 0; k < 5; k++) begin
      int w;
      w = k % NREQ;
      serve($sformatf("cont%0d", k), 4'(1 << w), 1'b0, 64'h1000 + 64'(w * 16), 64'(w), 64'h55);
      req[w] = 1'b1;
    end
    req = '0;

    // Requester 1 drops its request and changes its address mid-access.
    set_slot(1, 1'b0, 64'h500, 64'h5);
    req       = 4'b0010;
    mem_rdata = 64'h77;
    tick();
    check("abort/gnt", 64'(gnt), 64'b0010);
    req = '0;
    set_slot(1, 1'b0, 64'hFFF, 64'hF);
    tick();
    check("abort/mem_en",   64'(mem_en), 64'd1);
    check("abort/mem_addr", mem_addr,    64'h500);
    tick();
    check("abort/ack",   64'(ack), 64'b0010);
    check("abort/rdata", rdata,    64'h77);
    tick();
    check("abort/ack_off", 64'(ack), 64'd0);
    check("abort/gnt_off", 64'(gnt), 64'd0);
    tick();
    check("abort/ack_once", 64'(ack),    64'd0);
    check("abort/idle_en",  64'(mem_en), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
